// File: rtl/stream_to_mem_writer.sv
// Stream sink to Avalon-MM single-word write master with a small elastic FIFO.
// Optional DMA_EOP_TERMINATE_EN: an accepted end-of-packet beat ends the transfer early.
module stream_to_mem_writer #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                slave_clk,
  input  logic                slave_reset_n,
  input  logic                cfg_start,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [LEN_W-1:0]    cfg_length,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    words_written,
  input  logic                snk_valid,
  input  logic [DATA_W-1:0]   snk_data,
  input  logic                snk_eop,
  output logic                snk_ready,
  output logic [ADDR_W-1:0]   av_address,
  output logic [DATA_W/8-1:0] av_byteenable,
  output logic                av_write,
  output logic [DATA_W-1:0]   av_writedata,
  input  logic                av_waitrequest
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      acc_q, acc_d;
  logic [LEN_W-1:0]      wcnt_q, wcnt_d;
  logic [PTR_W:0]        wptr_q, wptr_d;
  logic [PTR_W:0]        rptr_q, rptr_d;
  logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];

  logic fifo_empty, fifo_full, run, push, pop;

  // Extra pointer MSB distinguishes full from empty.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign run        = (state_q == RUN);

  assign snk_ready  = run && !fifo_full && (acc_q < len_q);
  assign push       = snk_valid && snk_ready;
  assign av_write   = run && !fifo_empty;
  assign pop        = av_write && !av_waitrequest;

`ifndef DMA_EOP_TERMINATE_EN
  logic unused_eop;
  assign unused_eop = snk_eop;
`endif

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      wcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage needs no reset: the head is only visible while the FIFO is non-empty.
  always_ff @(posedge slave_clk) begin
    if (push) mem_q[wptr_q[PTR_W-1:0]] <= snk_data;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          addr_d  = cfg_base_addr;
          len_d   = cfg_length;
          acc_d   = '0;
          wcnt_d  = '0;
          wptr_d  = '0;
          rptr_d  = '0;
          state_d = (cfg_length != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (push) begin
          wptr_d = wptr_q + 1'b1;
          acc_d  = acc_q + 1'b1;
`ifdef DMA_EOP_TERMINATE_EN
          // Shrinking the target to the beats seen so far closes the sink.
          if (snk_eop) len_d = acc_q + 1'b1;
`endif
        end
        if (pop) begin
          rptr_d = rptr_q + 1'b1;
          addr_d = addr_q + 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_d == len_d) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign av_address    = addr_q;
  assign av_writedata  = av_write ? mem_q[rptr_q[PTR_W-1:0]] : '0;
  assign av_byteenable = {(DATA_W/8){av_write}};
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign words_written = wcnt_q;

endmodule

// File: tb/tb_stream_to_mem_writer.sv
// Scoreboard bench for stream_to_mem_writer: expected writes queued at beat acceptance,
// popped and compared as the master issues them.
module tb_stream_to_mem_writer;
  logic        slave_clk = 1'b0;
  logic        slave_reset_n;
  logic        cfg_start;
  logic [27:0] cfg_base_addr;
  logic [23:0] cfg_length;
  logic        busy, done;
  logic [23:0] words_written;
  logic        snk_valid;
  logic [31:0] snk_data;
  logic        snk_eop;
  logic        snk_ready;
  logic [27:0] av_address;
  logic [3:0]  av_byteenable;
  logic        av_write;
  logic [31:0] av_writedata;
  logic        av_waitrequest;

  stream_to_mem_writer dut (
    .slave_clk(slave_clk), .slave_reset_n(slave_reset_n),
    .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr), .cfg_length(cfg_length),
    .busy(busy), .done(done), .words_written(words_written),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_eop(snk_eop), .snk_ready(snk_ready),
    .av_address(av_address), .av_byteenable(av_byteenable), .av_write(av_write),
    .av_writedata(av_writedata), .av_waitrequest(av_waitrequest)
  );

  always #5 slave_clk = ~slave_clk;

  typedef struct packed {
    logic [27:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc, n_iss, max_hold, last_cyc;
  logic ext_wait = 1'b0;
  int   stall_idx = -1;
  int   stall_n = 0;

  task automatic start_xfer(input logic [27:0] base, input logic [23:0] len);
    cfg_start = 1'b1; cfg_base_addr = base; cfg_length = len;
    @(posedge slave_clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic drive_beats(input logic [27:0] base, input int n, input logic [31:0] d0,
                             input int eop_idx);
    exp_t e;
    int   t;
    n_acc = 0;
    for (int i = 0; i < n; i++) begin
      snk_valid = 1'b1; snk_data = d0 + 32'(i); snk_eop = (i == eop_idx);
      t = 0;
      @(negedge slave_clk);
      while (!snk_ready && t < 200) begin t++; @(negedge slave_clk); end
      if (!snk_ready) begin
        n_cmp++; n_err++;
        $display("FAIL sink_timeout beat=%0d ready=%b required=1", i, snk_ready);
        break;
      end
      e.a = base + 28'(i); e.d = d0 + 32'(i);
      sb.push_back(e);
      n_acc++;
      @(posedge slave_clk); #1;
    end
    snk_valid = 1'b0; snk_eop = 1'b0;
  endtask

  // Issue monitor: drives waitrequest, checks hold stability, scoreboard order, done pulse.
  task automatic watch(input int n_exp, input int max_cyc);
    logic        pw, st;
    logic [27:0] pa;
    logic [31:0] pd;
    int          hold, cyc, stalled;
    exp_t        e;
    pw = 1'b0; pa = '0; pd = '0; hold = 0; cyc = 0; stalled = 0;
    n_iss = 0; max_hold = 0;
    while (n_iss < n_exp && cyc < max_cyc) begin
      @(negedge slave_clk); cyc++;
      st = av_write && (n_iss == stall_idx) && (stalled < stall_n);
      if (st) stalled++;
      av_waitrequest = ext_wait | st;
      if (pw) begin
        n_cmp++;
        if (av_write !== 1'b1 || av_address !== pa || av_writedata !== pd) begin
          n_err++;
          $display("FAIL hold_stable addr=%h data=%h required addr=%h data=%h", av_address, av_writedata, pa, pd);
        end
      end
      if (av_write) begin
        hold++;
        n_cmp++;
        if (av_byteenable !== 4'hF) begin
          n_err++; $display("FAIL byteenable got=%h required=f", av_byteenable);
        end
        if (!av_waitrequest) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++; $display("FAIL unexpected_write addr=%h data=%h", av_address, av_writedata);
          end else begin
            e = sb.pop_front();
            if (av_address !== e.a || av_writedata !== e.d) begin
              n_err++;
              $display("FAIL write_%0d addr=%h data=%h required addr=%h data=%h", n_iss, av_address, av_writedata, e.a, e.d);
            end
          end
          n_iss++;
          if (hold > max_hold) max_hold = hold;
          hold = 0;
        end
      end
      pw = av_write && av_waitrequest; pa = av_address; pd = av_writedata;
    end
    last_cyc = cyc;
    if (n_iss < n_exp) begin
      n_cmp++; n_err++; $display("FAIL watch_timeout issued=%0d required=%0d", n_iss, n_exp);
    end
    @(negedge slave_clk);
    av_waitrequest = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || av_write !== 1'b0 || words_written !== 24'(n_exp)) begin
      n_err++;
      $display("FAIL done_pulse done=%b av_write=%b words=%0d required 1/0/%0d", done, av_write, words_written, n_exp);
    end
    @(negedge slave_clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL done_end done=%b busy=%b required 0/0", done, busy);
    end
    @(posedge slave_clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || words_written !== 24'h0 || snk_ready !== 1'b0) begin
      n_err++; $display("FAIL %s_ctl busy=%b done=%b words=%0d ready=%b required 0", tag, busy, done, words_written, snk_ready);
    end
    n_cmp++;
    if (av_write !== 1'b0 || av_address !== 28'h0 || av_writedata !== 32'h0 || av_byteenable !== 4'h0) begin
      n_err++; $display("FAIL %s_av write=%b addr=%h data=%h be=%h required 0", tag, av_write, av_address, av_writedata, av_byteenable);
    end
  endtask

  task automatic test_reset();
    slave_reset_n = 1'b0; cfg_start = 1'b0; cfg_base_addr = '0; cfg_length = '0;
    snk_valid = 1'b0; snk_data = '0; snk_eop = 1'b0; av_waitrequest = 1'b0;
    repeat (2) @(posedge slave_clk); #1;
    check_reset_outputs("reset");
    slave_reset_n = 1'b1;
    @(posedge slave_clk); #1;
  endtask

  task automatic test_basic();
    start_xfer(28'h0000100, 24'd4);
    fork
      drive_beats(28'h0000100, 4, 32'hA0, -1);
      watch(4, 100);
    join
    // First write one cycle after first acceptance, then one per cycle.
    n_cmp++;
    if (last_cyc != 5) begin
      n_err++; $display("FAIL basic_throughput cycles=%0d required=5", last_cyc);
    end
  endtask

  task automatic test_waitrequest();
    stall_idx = 1; stall_n = 3;
    start_xfer(28'h0000100, 24'd4);
    fork
      drive_beats(28'h0000100, 4, 32'hA0, -1);
      watch(4, 100);
    join
    n_cmp++;
    if (max_hold != 4) begin
      n_err++; $display("FAIL stall_hold cycles=%0d required=4", max_hold);
    end
    stall_idx = -1; stall_n = 0;
  endtask

  task automatic test_fifo_full();
    ext_wait = 1'b1; av_waitrequest = 1'b1;
    start_xfer(28'h0000800, 24'd16);
    fork
      drive_beats(28'h0000800, 16, 32'hB00, -1);
      watch(16, 200);
      begin
        repeat (18) @(negedge slave_clk);
        n_cmp++;
        if (n_acc != 8 || snk_ready !== 1'b0 || av_write !== 1'b1) begin
          n_err++; $display("FAIL fifo_full accepted=%0d ready=%b write=%b required 8/0/1", n_acc, snk_ready, av_write);
        end
        @(posedge slave_clk); #1;
        ext_wait = 1'b0;
      end
    join
  endtask

  task automatic test_wrap();
    start_xfer(28'hFFFFFFE, 24'd4);
    fork
      drive_beats(28'hFFFFFFE, 4, 32'hD0, -1);
      watch(4, 100);
    join
  endtask

  task automatic test_zero_len();
    start_xfer(28'h0000040, 24'd0);
    @(negedge slave_clk);
    n_cmp++;
    if (done !== 1'b1 || av_write !== 1'b0 || words_written !== 24'd0) begin
      n_err++; $display("FAIL zero_len done=%b write=%b words=%0d required 1/0/0", done, av_write, words_written);
    end
    @(negedge slave_clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL zero_len_end done=%b busy=%b required 0/0", done, busy);
    end
    @(posedge slave_clk); #1;
  endtask

  task automatic test_start_ignored();
    start_xfer(28'h0000300, 24'd4);
    fork
      drive_beats(28'h0000300, 4, 32'hC0, -1);
      watch(4, 100);
      begin
        repeat (2) @(posedge slave_clk); #1;
        cfg_start = 1'b1; cfg_base_addr = 28'h0000500; cfg_length = 24'd1;
        @(posedge slave_clk); #1;
        cfg_start = 1'b0;
      end
    join
  endtask

  task automatic test_abort();
    int iss, t;
    iss = 0; t = 0;
    start_xfer(28'h0000200, 24'd8);
    snk_valid = 1'b1; snk_data = 32'hF0;
    while (iss < 2 && t < 50) begin
      @(negedge slave_clk); t++;
      if (av_write && !av_waitrequest) begin
        n_cmp++;
        if (av_address !== 28'h200 + 28'(iss)) begin
          n_err++; $display("FAIL abort_addr got=%h required=%h", av_address, 28'h200 + 28'(iss));
        end
        iss++;
      end
    end
    @(posedge slave_clk); #1;
    n_cmp++;
    if (words_written !== 24'd2 || busy !== 1'b1) begin
      n_err++; $display("FAIL abort_pre words=%0d busy=%b required 2/1", words_written, busy);
    end
    slave_reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    snk_valid = 1'b0;
    @(posedge slave_clk); #1;
    slave_reset_n = 1'b1;
    @(posedge slave_clk); #1;
  endtask

  task automatic test_eop();
`ifdef DMA_EOP_TERMINATE_EN
    start_xfer(28'h0000400, 24'd10);
    fork
      begin
        drive_beats(28'h0000400, 3, 32'hE0, 2);
        @(negedge slave_clk);
        n_cmp++;
        if (snk_ready !== 1'b0) begin
          n_err++; $display("FAIL eop_close ready=%b required=0", snk_ready);
        end
      end
      watch(3, 100);
    join
`else
    start_xfer(28'h0000400, 24'd4);
    fork
      drive_beats(28'h0000400, 4, 32'hE0, 1);
      watch(4, 100);
    join
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_waitrequest();
    test_fifo_full();
    test_wrap();
    test_zero_len();
    test_start_ignored();
    test_abort();
    test_eop();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL leftover_expected count=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
